// File: rtl/pipe_ctrl_if.sv
// Bus interface between the pipeline sequencer and the rest of the armv7 core.
// The master modport belongs to pipe_ctrl; the slave modport is the core side.
// PIPE_CTRL_PERF_EN adds the retired-instruction and flush counters to the bundle.
interface pipe_ctrl_if #(
  parameter int PHASES = 4
);
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

  // Core-side inputs to the sequencer
  logic          hold;
  logic [31:0]   instr;
  logic [3:0]    instr_type;
  logic [31:0]   pc;
  logic [31:0]   cspr;
  logic [31:0]   alu_result;
  logic [3:0]    alu_nzcv;
  logic          alu_writeback;

  // Sequencer outputs
  logic [PW-1:0] phase;
  logic          ir_read_enable;
  logic [31:0]   fd_instr;
  logic          fd_valid;
  logic [31:0]   de_instr;
  logic          de_valid;
  logic          reg_write_enable;
  logic [3:0]    write_address;
  logic [31:0]   write_data;
  logic          pc_write;
  logic [31:0]   pc_update;
  logic          cspr_write;
  logic [31:0]   cspr_update;
  logic          illegal;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   retired_cnt;
  logic [31:0]   flush_cnt;
`endif

  modport master (
    input  hold, instr, instr_type, pc, cspr, alu_result, alu_nzcv, alu_writeback,
`ifdef PIPE_CTRL_PERF_EN
    output retired_cnt, flush_cnt,
`endif
    output phase, ir_read_enable, fd_instr, fd_valid, de_instr, de_valid,
           reg_write_enable, write_address, write_data,
           pc_write, pc_update, cspr_write, cspr_update, illegal
  );

  modport slave (
    output hold, instr, instr_type, pc, cspr, alu_result, alu_nzcv, alu_writeback,
`ifdef PIPE_CTRL_PERF_EN
    input  retired_cnt, flush_cnt,
`endif
    input  phase, ir_read_enable, fd_instr, fd_valid, de_instr, de_valid,
           reg_write_enable, write_address, write_data,
           pc_write, pc_update, cspr_write, cspr_update, illegal
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: fetch/decode/execute sequencer for the armv7 core.
// Each pipeline cycle lasts PHASES clk cycles; the last one is the commit cycle,
// where the write strobes fire and the F/DE and DE/EX registers advance.
// Taken branches and R15 writes squash both in-flight instructions.
// Optional: define PIPE_CTRL_PERF_EN for retired_cnt / flush_cnt counters.
module pipe_ctrl #(
  parameter int          PHASES  = 4,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input logic        clk,
  input logic        reset,
  pipe_ctrl_if.master bus
);
  localparam int           PW      = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] LAST   = PW'(PHASES - 1);
  localparam logic [3:0]   TYPE_DP = 4'd7;
  localparam logic [3:0]   TYPE_BR = 4'd11;

  logic [PW-1:0] phase_q, phase_d;
  logic [31:0]   fd_instr_q, fd_instr_d;
  logic [31:0]   de_instr_q, de_instr_d;
  logic          fd_valid_q, fd_valid_d;
  logic          de_valid_q, de_valid_d;

  logic          commit;
  logic          cond_pass;
  logic          exec;
  logic          flush;
  logic          reg_write_enable;
  logic [3:0]    write_address;
  logic [31:0]   write_data;
  logic          pc_write;
  logic [31:0]   pc_update;
  logic          cspr_write;
  logic [31:0]   cspr_update;
  logic          illegal;

  logic          flag_n, flag_z, flag_c, flag_v;
  logic [3:0]    rd;
  logic [31:0]   br_offset;

  assign flag_n    = bus.cspr[31];
  assign flag_z    = bus.cspr[30];
  assign flag_c    = bus.cspr[29];
  assign flag_v    = bus.cspr[28];
  assign rd        = de_instr_q[15:12];
  assign br_offset = {{6{de_instr_q[23]}}, de_instr_q[23:0], 2'b00};

  // The commit cycle is the last phase of a pipeline cycle unless the core is stalling.
  assign commit = (phase_q == LAST) && !bus.hold;
  assign exec   = de_valid_q && cond_pass;

  // ARM condition-code evaluation of the instruction in execute against the live flags.
  always_comb begin
    cond_pass = 1'b0;
    case (de_instr_q[31:28])
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Write strobes for register file, PC and CSPR; only ever raised in the commit cycle.
  always_comb begin
    reg_write_enable = 1'b0;
    write_address    = 4'd0;
    write_data       = 32'd0;
    pc_write         = 1'b0;
    pc_update        = 32'd0;
    cspr_write       = 1'b0;
    cspr_update      = 32'd0;
    illegal          = 1'b0;
    flush            = 1'b0;
    if (commit) begin
      pc_write  = 1'b1;
      pc_update = bus.pc + PC_STEP;
      if (exec) begin
        case (bus.instr_type)
          TYPE_DP: begin
            if (bus.alu_writeback) begin
              if (rd != 4'd15) begin
                reg_write_enable = 1'b1;
                write_address    = rd;
                write_data       = bus.alu_result;
              end else begin
                pc_update = bus.alu_result;
                flush     = 1'b1;
              end
            end
            if (de_instr_q[20]) begin
              cspr_write  = 1'b1;
              cspr_update = {bus.alu_nzcv, bus.cspr[27:0]};
            end
          end
          TYPE_BR: begin
            pc_update = bus.pc + br_offset;
            flush     = 1'b1;
            if (de_instr_q[24]) begin
              reg_write_enable = 1'b1;
              write_address    = 4'd14;
              write_data       = bus.pc - 32'd4;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
    end
  end

  // Next phase and next pipeline-register contents; advance happens only on commit.
  always_comb begin
    phase_d    = phase_q + PW'(1);
    fd_instr_d = fd_instr_q;
    de_instr_d = de_instr_q;
    fd_valid_d = fd_valid_q;
    de_valid_d = de_valid_q;
    if (phase_q == LAST) begin
      phase_d = bus.hold ? phase_q : '0;
    end
    if (commit) begin
      de_instr_d = fd_instr_q;
      fd_instr_d = bus.instr;
      de_valid_d = flush ? 1'b0 : fd_valid_q;
      fd_valid_d = !flush;
    end
  end

  // Phase counter and pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      fd_instr_q <= 32'd0;
      de_instr_q <= 32'd0;
      fd_valid_q <= 1'b0;
      de_valid_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      fd_instr_q <= fd_instr_d;
      de_instr_q <= de_instr_d;
      fd_valid_q <= fd_valid_d;
      de_valid_q <= de_valid_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Performance counters: executed instructions and pipeline squashes, wrapping freely.
  always_comb begin
    retired_cnt_d = retired_cnt_q + 32'(commit && exec);
    flush_cnt_d   = flush_cnt_q + 32'(flush);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_q <= 32'd0;
      flush_cnt_q   <= 32'd0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.retired_cnt = retired_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
`endif

  assign bus.phase            = phase_q;
  assign bus.ir_read_enable   = (phase_q == '0);
  assign bus.fd_instr         = fd_instr_q;
  assign bus.fd_valid         = fd_valid_q;
  assign bus.de_instr         = de_instr_q;
  assign bus.de_valid         = de_valid_q;
  assign bus.reg_write_enable = reg_write_enable;
  assign bus.write_address    = write_address;
  assign bus.write_data       = write_data;
  assign bus.pc_write         = pc_write;
  assign bus.pc_update        = pc_update;
  assign bus.cspr_write       = cspr_write;
  assign bus.cspr_update      = cspr_update;
  assign bus.illegal          = illegal;
endmodule
